gals_collector_rr: RTL
======================

GALS_COLLECTOR_RR -- requirements
Module: gals_collector_rr

Interface
REQ-001 Parameter OUT_NEURONS, default 64, SHALL be the number of PE done-handshake channels (>=2).
REQ-002 Parameter WDOG_W, default 16, SHALL be the width of the programmable watchdog limit.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL be the synchroniser depth on PE requests (>=2).
REQ-004 local_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 i_aer_req  in  1  global four-phase request: start a collection round.
REQ-007 o_aer_ack  out  1  global four-phase acknowledge: round complete.
REQ-008 i_expect_mask  in  OUT_NEURONS  channels taking part in the round; sampled at round start.
REQ-009 i_wdog_limit  in  WDOG_W  no-progress cycle limit; sampled at round start; 0 disables the watchdog.
REQ-010 i_pe_done_req_vec  in  OUT_NEURONS  per-PE asynchronous done requests.
REQ-011 o_pe_done_ack_vec  out  OUT_NEURONS  per-PE acknowledges; one-hot or zero.
REQ-012 o_done_vec  out  OUT_NEURONS  channels completed in the current round.
REQ-013 o_done_cnt  out  clog2(OUT_NEURONS)+1  population count of o_done_vec.
REQ-014 o_error  out  1  sticky watchdog timeout flag.
REQ-015 o_err_idx  out  clog2(OUT_NEURONS)  channel being served at timeout (0 if none).
REQ-016 i_err_clr  in  1  single-cycle pulse that clears the error and returns to idle.
REQ-017 o_busy  out  1  high in every state except IDLE.

Function
REQ-018 Every i_pe_done_req_vec bit SHALL pass through SYNC_STAGES flops; only the synchronised value (req_s) is used.
REQ-019 All outputs SHALL be registered.
REQ-020 States: IDLE, SCAN, ACK, GACK, ERR.
REQ-021 IDLE: on i_aer_req=1, latch mask and limit; clear done_vec, done_cnt and the watchdog; go to SCAN next cycle.
REQ-022 SCAN: pending = req_s & mask & ~done_vec; if pending is nonzero, a round-robin arbiter SHALL grant the lowest set index at or above rr_ptr (wrapping), latch it, and go to ACK.
REQ-023 SCAN: if done_vec==mask (including mask==0), go to GACK.
REQ-024 ACK entry SHALL assert o_pe_done_ack_vec[idx] one cycle after the grant.
REQ-025 ACK SHALL hold that ack high until req_s[idx]==0.
REQ-026 When req_s[idx]==0: deassert the ack; set done_vec[idx]; increment done_cnt; set rr_ptr=idx+1 mod OUT_NEURONS; return to SCAN.
REQ-027 No channel SHALL be acked twice in one round.
REQ-028 Requests on unmasked channels SHALL be ignored and never acked.
REQ-029 GACK: o_aer_ack=1, held until i_aer_req=0.
REQ-030 On i_aer_req=0 in GACK: o_aer_ack=0 and go to IDLE (full four-phase).
REQ-031 Watchdog: counts cycles in SCAN or ACK without progress.
REQ-032 Watchdog reset: cleared on each grant and each completed channel.
REQ-033 Watchdog trip: when the count reaches a nonzero limit, go to ERR.
REQ-034 ERR: o_error=1, o_err_idx=latched idx (0 if the trip was in SCAN), all acks=0, o_aer_ack=0.
REQ-035 ERR exit: i_err_clr=1 SHALL clear o_error and go to IDLE; no other exit exists.
REQ-036 i_err_clr SHALL be ignored outside ERR.
REQ-037 done_vec and done_cnt SHALL hold their values through GACK and IDLE until the next round start.
REQ-038 rr_ptr SHALL persist across rounds; it is cleared only by reset.
REQ-039 The watchdog counter SHALL saturate and never wrap.

Reset
REQ-040 rst=1 SHALL immediately force state=IDLE and all outputs to 0.
REQ-041 rst=1 SHALL clear the synchronisers, done_vec, rr_ptr, latched mask/limit/idx and the watchdog.
REQ-042 Reset asserted mid-round SHALL abandon the round; the ack drops asynchronously.

Structure
REQ-043 Shared package gals_pkg SHALL hold the state enum and an index-width function.
REQ-044 Round-robin grant SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs valid and idx), purely combinational.

Verification
REQ-045 N=8, mask=0xFF, all PE requests high, rr_ptr=0 -> acks granted in order 0..7, o_done_cnt=8, then o_aer_ack=1 until i_aer_req drops.
REQ-046 mask=0x05, requests on all channels -> only channels 0 and 2 acked; o_done_vec=0x05.
REQ-047 mask=0 -> o_aer_ack asserts within 3 cycles of i_aer_req with no PE acks.
REQ-048 Second round after ending at idx 5, requests on 2 and 6 -> 6 is granted before 2.
REQ-049 limit=10, PE 3 never drops its request -> o_error=1 with o_err_idx=3; i_err_clr -> IDLE, ack cleared.
REQ-050 rst pulsed during ACK -> all outputs 0 asynchronously; a new round completes normally.

Source files
------------

// File: rtl/gals_pkg.sv
// Shared types and helpers for the GALS done-collector: FSM state encoding
// and the index-width calculation used for channel indices.
package gals_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_ACK  = 3'd2,
    ST_GACK = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr,
// wrapping to the lowest requesting index overall.
module rr_arbiter
  import gals_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]          req_i,
  input  logic [idx_w(N)-1:0]   ptr_i,
  output logic                  valid_o,
  output logic [idx_w(N)-1:0]   idx_o
);

  localparam int IW = idx_w(N);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[k] && (k >= int'(ptr_i))) begin
        valid_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
    // Nothing at or above the pointer: wrap around.
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/gals_collector_rr.sv
// Collects per-PE four-phase done handshakes in round-robin order and answers
// the global AER request once every expected channel has completed.
module gals_collector_rr
  import gals_pkg::*;
#(
  parameter int OUT_NEURONS = 64,
  parameter int WDOG_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           local_clk,
  input  logic                           rst,
  input  logic                           i_aer_req,
  output logic                           o_aer_ack,
  input  logic [OUT_NEURONS-1:0]         i_expect_mask,
  input  logic [WDOG_W-1:0]              i_wdog_limit,
  input  logic [OUT_NEURONS-1:0]         i_pe_done_req_vec,
  output logic [OUT_NEURONS-1:0]         o_pe_done_ack_vec,
  output logic [OUT_NEURONS-1:0]         o_done_vec,
  output logic [$clog2(OUT_NEURONS):0]   o_done_cnt,
  output logic                           o_error,
  output logic [idx_w(OUT_NEURONS)-1:0]  o_err_idx,
  input  logic                           i_err_clr,
  output logic                           o_busy,
  output logic [2:0]                     o_state_dbg
);

  localparam int IW = idx_w(OUT_NEURONS);
  localparam int CW = $clog2(OUT_NEURONS) + 1;

  // Handshakes are four-phase: the requester raises req, the responder raises
  // ack, the requester drops req, the responder drops ack. Both the global
  // AER pair and each PE done pair follow this; PE reqs are asynchronous.
  state_e                 state_q, state_d;
  logic [OUT_NEURONS-1:0] sync_q [SYNC_STAGES];
  logic [OUT_NEURONS-1:0] req_s, pending;
  logic [OUT_NEURONS-1:0] mask_q, mask_d, done_vec_q, done_vec_d, ack_q, ack_d;
  logic [WDOG_W-1:0]      limit_q, limit_d, wdog_q, wdog_d, wdog_inc;
  logic [IW-1:0]          idx_q, idx_d, rr_ptr_q, rr_ptr_d, err_idx_q, err_idx_d, gnt_idx;
  logic [CW-1:0]          done_cnt_q, done_cnt_d;
  logic                   aer_ack_q, aer_ack_d, error_q, error_d, busy_q;
  logic                   gnt_valid, wdog_trip;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s & mask_q & ~done_vec_q;

  rr_arbiter #(.N(OUT_NEURONS)) u_arb (
    .req_i   (pending),
    .ptr_i   (rr_ptr_q),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  assign wdog_inc  = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
  assign wdog_trip = (limit_q != '0) && (wdog_inc >= limit_q);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    limit_d    = limit_q;
    idx_d      = idx_q;
    done_vec_d = done_vec_q;
    done_cnt_d = done_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    ack_d      = ack_q;
    aer_ack_d  = aer_ack_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_aer_req) begin
          mask_d     = i_expect_mask;
          limit_d    = i_wdog_limit;
          done_vec_d = '0;
          done_cnt_d = '0;
          wdog_d     = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (done_vec_q == mask_q) begin
          aer_ack_d = 1'b1;
          state_d   = ST_GACK;
        end else if (gnt_valid) begin
          idx_d          = gnt_idx;
          ack_d          = '0;
          ack_d[gnt_idx] = 1'b1;
          wdog_d         = '0;
          state_d        = ST_ACK;
        end else if (wdog_trip) begin
          error_d   = 1'b1;
          err_idx_d = '0;
          state_d   = ST_ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_ACK: begin
        if (!req_s[idx_q]) begin
          ack_d             = '0;
          done_vec_d[idx_q] = 1'b1;
          done_cnt_d        = done_cnt_q + CW'(1);
          rr_ptr_d          = (idx_q == IW'(OUT_NEURONS - 1)) ? '0 : idx_q + IW'(1);
          wdog_d            = '0;
          state_d           = ST_SCAN;
        end else if (wdog_trip) begin
          ack_d     = '0;
          error_d   = 1'b1;
          err_idx_d = idx_q;
          state_d   = ST_ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_GACK: begin
        if (!i_aer_req) begin
          aer_ack_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (i_err_clr) begin
          error_d   = 1'b0;
          err_idx_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      limit_q    <= '0;
      idx_q      <= '0;
      done_vec_q <= '0;
      done_cnt_q <= '0;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      ack_q      <= '0;
      aer_ack_q  <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync_q[0] <= i_pe_done_req_vec;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      state_q    <= state_d;
      mask_q     <= mask_d;
      limit_q    <= limit_d;
      idx_q      <= idx_d;
      done_vec_q <= done_vec_d;
      done_cnt_q <= done_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
      ack_q      <= ack_d;
      aer_ack_q  <= aer_ack_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign o_aer_ack         = aer_ack_q;
  assign o_pe_done_ack_vec = ack_q;
  assign o_done_vec        = done_vec_q;
  assign o_done_cnt        = done_cnt_q;
  assign o_error           = error_q;
  assign o_err_idx         = err_idx_q;
  assign o_busy            = busy_q;
  assign o_state_dbg       = state_q;

endmodule
